// File: rtl/snn_pkg.sv
// snn_pkg: shared constants, config field layout and
// arithmetic helpers for the spiking layer.
package snn_pkg;

  localparam int SNN_DEF_SHIFT  = 1;
  localparam int SNN_DEF_THRESH = 128;

  // cfg_data = {shift, thresh}; shift sits above thresh
  localparam int CFG_SHIFT_W    = 3;
  localparam int CFG_THRESH_LSB = 0;

  // widest vector the popcount helper accepts
  localparam int POP_MAX = 1024;

  function automatic int unsigned cfg_shift_lsb(
    input int unsigned state_w
  );
    return state_w;
  endfunction

  // a + b clamped to 2^w - 1
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

  function automatic logic [31:0] popcount(
    input logic [POP_MAX-1:0] v
  );
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++)
      c = c + {31'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/snn_layer_lif.sv
// lif_neuron: one leaky integrate-and-fire hidden neuron
// with refractory hold-off.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int STATE_W = 8,
  parameter int REFRAC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    in1,
  input  logic [2:0]         shift,
  input  logic [STATE_W-1:0] thresh,
  output logic               spike,
  output logic [STATE_W-1:0] mem
);

  localparam int RC_W =
    (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [RC_W-1:0]    r_refrac;
  logic [STATE_W-1:0] r_mem;
  logic               r_spike;
  logic [STATE_W-1:0] w_leak;
  logic [STATE_W-1:0] w_sum;

  // leak and saturating integrate of the shared input
  always_comb begin
    w_leak = '0;
    if (shift != 3'd0)
      w_leak = r_mem >> shift;
    w_sum = STATE_W'(sat_add(32'(r_mem - w_leak),
                             32'(in1), STATE_W));
  end

  // membrane, refractory counter and spike register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refrac <= '0;
      r_mem    <= '0;
      r_spike  <= 1'b0;
    end else if (r_refrac != '0) begin
      r_refrac <= r_refrac - RC_W'(1);
      r_mem    <= '0;
      r_spike  <= 1'b0;
    end else if (thresh == '0) begin
      r_mem    <= '0;
      r_spike  <= 1'b0;
    end else if (w_sum >= thresh) begin
      r_refrac <= RC_W'(REFRAC);
      r_mem    <= '0;
      r_spike  <= 1'b1;
    end else begin
      r_mem    <= w_sum;
      r_spike  <= 1'b0;
    end
  end

  assign spike = r_spike;
  assign mem   = r_mem;

endmodule

// File: rtl/snn_layer.sv
// snn_layer: grouped LIF hidden layer with programmable
// per-group leak/threshold, readout neurons and counters.
module snn_layer
  import snn_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int STATE_W     = 8,
  parameter int N_GROUPS    = 8,
  parameter int N_PER_GROUP = 16,
  parameter int N_OUT       = 2,
  parameter int REFRAC      = 2,
  parameter int DEF_SHIFT   = SNN_DEF_SHIFT,
  parameter int DEF_THRESH  = SNN_DEF_THRESH,
  parameter int OUT_THRESH  = 64,
  parameter int CNT_W       = 16,
  localparam int GA_W =
    (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  // spare top bit so out-of-range indices are rejected
  localparam int AW = GA_W + 1,
  localparam int CW = CFG_SHIFT_W + STATE_W,
  localparam int NH = N_GROUPS * N_PER_GROUP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          in1,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [CW-1:0]            cfg_data,
  input  logic                     cnt_clr,
  output logic [NH-1:0]            hidden_spike,
  output logic [N_OUT-1:0]         spike_out,
  output logic [N_OUT*STATE_W-1:0] state_out,
  output logic [N_OUT*CNT_W-1:0]   spike_cnt
);

  localparam int PART = NH / N_OUT;
  localparam int P_W  = $clog2(PART + 1);
  localparam int SH_L = int'(cfg_shift_lsb(STATE_W));

  logic [2:0]         r_shift  [N_GROUPS];
  logic [STATE_W-1:0] r_thresh [N_GROUPS];
  logic [STATE_W-1:0] w_hmem_unused [NH];

  logic [GA_W-1:0]    w_gidx;
  logic               w_cfg_ok;
  logic [2:0]         w_cfg_shift;
  logic [STATE_W-1:0] w_cfg_thresh;

  logic [N_OUT-1:0][PART-1:0] w_part;
  logic [P_W-1:0]     w_pop   [N_OUT];
  logic [STATE_W-1:0] w_rsum  [N_OUT];
  logic [N_OUT-1:0]   w_rfire;

  logic [STATE_W-1:0] r_rmem  [N_OUT];
  logic [N_OUT-1:0]   r_rspike;
  logic [CNT_W-1:0]   r_cnt   [N_OUT];

  assign w_gidx       = cfg_addr[GA_W-1:0];
  assign w_cfg_ok     = int'(cfg_addr) < N_GROUPS;
  assign w_cfg_shift  = cfg_data[SH_L +: CFG_SHIFT_W];
  assign w_cfg_thresh = cfg_data[CFG_THRESH_LSB +: STATE_W];

  // per-group config table; writes land at the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < N_GROUPS; g++) begin
        r_shift[g]  <= 3'(DEF_SHIFT);
        r_thresh[g] <= STATE_W'(DEF_THRESH);
      end
    end else if (cfg_we && w_cfg_ok) begin
      r_shift[w_gidx]  <= w_cfg_shift;
      r_thresh[w_gidx] <= w_cfg_thresh;
    end
  end

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
    for (genvar n = 0; n < N_PER_GROUP; n++) begin : g_nrn
      lif_neuron #(
        .IN_W    (IN_W),
        .STATE_W (STATE_W),
        .REFRAC  (REFRAC)
      ) u_lif (
        .clk    (clk),
        .reset  (reset),
        .in1    (in1),
        .shift  (r_shift[g]),
        .thresh (r_thresh[g]),
        .spike  (hidden_spike[g*N_PER_GROUP+n]),
        .mem    (w_hmem_unused[g*N_PER_GROUP+n])
      );
    end
  end

  // gather each readout's interleaved partition
  always_comb begin
    w_part = '0;
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < PART; j++)
        w_part[k][j] = hidden_spike[j*N_OUT+k];
  end

  // readout leak-by-half plus spike popcount
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      w_pop[k]   = P_W'(popcount(POP_MAX'(w_part[k])));
      w_rsum[k]  = STATE_W'(sat_add(
                     32'(r_rmem[k] - (r_rmem[k] >> 1)),
                     32'(w_pop[k]), STATE_W));
      w_rfire[k] = 32'(w_rsum[k]) >= 32'(OUT_THRESH);
    end
  end

  // readout membranes, spikes and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rspike <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        r_rmem[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      r_rspike <= w_rfire;
      for (int k = 0; k < N_OUT; k++) begin
        r_rmem[k] <= w_rfire[k] ? '0 : w_rsum[k];
        if (cnt_clr)
          r_cnt[k] <= '0;
        else if (w_rfire[k] && r_cnt[k] != '1)
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  // flatten readout state onto the output buses
  always_comb begin
    spike_out = r_rspike;
    state_out = '0;
    spike_cnt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      state_out[k*STATE_W +: STATE_W] = r_rmem[k];
      spike_cnt[k*CNT_W +: CNT_W]     = r_cnt[k];
    end
  end

endmodule
